// File: rtl/manycore_noc_pkg.sv
// Shared NoC definitions: flit width default, transmitter state encoding and
// router address field helpers (x in addr[7:4], y in addr[3:0]).
package manycore_noc_pkg;

    localparam int unsigned FLIT_WIDTH_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_SIZE  = 2'd2;
    localparam logic [1:0] ST_PAYLD = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        HDR   = ST_HDR,
        SIZE  = ST_SIZE,
        PAYLD = ST_PAYLD
    } tx_state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } noc_xy_t;

    function automatic noc_xy_t addr_to_xy(input logic [7:0] addr);
        return addr;
    endfunction

    function automatic logic [7:0] xy_to_addr(input logic [3:0] x, input logic [3:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/noc_port_tx.sv
// Credit-based flit transmitter: emits header, size and payload flits into a
// router input port, holding each flit in the output register until credited.
module noc_port_tx
    import manycore_noc_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = FLIT_WIDTH_DEF,
    parameter int unsigned SIZE_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_in,
    input  logic [FLIT_WIDTH-1:0] dest_in,
    input  logic [SIZE_WIDTH-1:0] size_in,
    output logic                  busy_out,
    output logic                  done_out,
    input  logic                  pl_valid_in,
    input  logic [FLIT_WIDTH-1:0] pl_data_in,
    output logic                  pl_ready_out,
    output logic                  clock_tx,
    output logic                  tx,
    output logic [FLIT_WIDTH-1:0] data_o,
    input  logic                  credit_i
);

    tx_state_t             state, state_nx;
    logic [SIZE_WIDTH-1:0] cnt, cnt_nx;
    logic [SIZE_WIDTH-1:0] size_r, size_nx;
    logic [FLIT_WIDTH-1:0] data_nx;
    logic                  tx_nx;
    logic                  done_nx;
    logic                  adv;
    logic                  cnt_nz;
    logic                  take;

    assign clock_tx = clock;
    assign busy_out = (state != IDLE);
    assign adv      = ~tx | credit_i;
    assign cnt_nz   = (cnt != '0);
    // First payload flit is fetched while the size flit drains, keeping one flit per cycle.
    assign pl_ready_out = ((state == PAYLD) | (state == SIZE)) & cnt_nz & adv;
    assign take         = pl_valid_in & pl_ready_out;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        size_nx  = size_r;
        data_nx  = data_o;
        tx_nx    = tx;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    size_nx  = size_in;
                    cnt_nx   = size_in;
                    data_nx  = dest_in;
                    tx_nx    = 1'b1;
                    state_nx = HDR;
                end
            end
            HDR: begin
                if (credit_i) begin
                    data_nx  = FLIT_WIDTH'(size_r);
                    state_nx = SIZE;
                end
            end
            SIZE, PAYLD: begin
                if (adv) begin
                    if (take) begin
                        data_nx  = pl_data_in;
                        tx_nx    = 1'b1;
                        cnt_nx   = cnt - SIZE_WIDTH'(1);
                        state_nx = PAYLD;
                    end else if (!cnt_nz) begin
                        tx_nx    = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        tx_nx    = 1'b0;
                        state_nx = PAYLD;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            size_r   <= '0;
            data_o   <= '0;
            tx       <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            size_r   <= size_nx;
            data_o   <= data_nx;
            tx       <= tx_nx;
            done_out <= done_nx;
        end
    end

endmodule
